sc_branch_cond_unit: RTL and testbench
======================================

Name: sc_branch_cond_unit

Overview:
Consumer side of the processor status register. It reads the registered N,Z,V,C flag word, evaluates SPARC Bicc condition codes for a decoded branch, and computes the branch target. A small FSM sequences the delay slot, decides whether that slot is annulled, and then issues a one-shot redirect to fetch. It sits between decode and the PC/fetch logic.

Parameters:
DATAWIDTH_ALU_SELECTION, 4, flag word width; bit order {N,Z,V,C}, N in the MSB.
DATAWIDTH_COND, 4, condition field width.
DATAWIDTH_DISP, 22, branch displacement width (word offset).
DATAWIDTH_PC, 32, PC and target width.

Ports:
SC_BranchCond_CLOCK_50  in  1  clock; all state updates on the rising edge.
SC_Psr_RESET_InHigh  in  1  reset, asynchronous, active-high.
SC_BranchCond_Psr_In  in  4  flag word {N,Z,V,C} from the status register.
SC_BranchCond_Valid_InHigh  in  1  decode holds a Bicc instruction.
SC_BranchCond_Cond_In  in  4  Bicc condition field.
SC_BranchCond_Annul_In  in  1  Bicc annul bit (a).
SC_BranchCond_Disp_In  in  22  signed word displacement.
SC_BranchCond_Pc_In  in  32  PC of the branch instruction.
SC_BranchCond_Stall_InHigh  in  1  pipeline stall; freezes the FSM.
SC_BranchCond_Taken_Out  out  1  registered branch decision.
SC_BranchCond_Target_Out  out  32  registered branch target.
SC_BranchCond_AnnulSlot_Out  out  1  kill the delay-slot instruction.
SC_BranchCond_Redirect_Out  out  1  fetch loads Target_Out.
SC_BranchCond_Busy_Out  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; every output is 0, including Target_Out = 32'h0.
- Condition table (1 = taken):
  - 0000 BN: 0
  - 0001 BE: Z
  - 0010 BLE: Z|(N^V)
  - 0011 BL: N^V
  - 0100 BLEU: C|Z
  - 0101 BCS: C
  - 0110 BNEG: N
  - 0111 BVS: V
  - 1000 BA: 1
  - 1001 BNE: !Z
  - 1010 BG: !(Z|(N^V))
  - 1011 BGE: !(N^V)
  - 1100 BGU: !(C|Z)
  - 1101 BCC: !C
  - 1110 BPOS: !N
  - 1111 BVC: !V
- Target = Pc_In + (sign_extend(Disp_In) << 2), computed modulo 2^32; wrap-around is silent.
- Annul decision:
  - a=0: never annul.
  - a=1, conditional branch (not BA/BN): annul only if not taken.
  - a=1, BA or BN: always annul.
- FSM states: IDLE, DELAY, REDIRECT.
- IDLE:
  - On Valid=1 and Stall=0: sample Psr_In, latch Taken, Target and the annul decision; go to DELAY (1-cycle latency).
  - Valid with Stall=1 is not accepted.
- DELAY:
  - Busy=1; AnnulSlot_Out = latched annul decision.
  - Stall=1 holds the state.
  - First non-stalled cycle: go to REDIRECT if taken, otherwise to IDLE.
- REDIRECT:
  - Redirect_Out=1 and AnnulSlot_Out=0.
  - Redirect_Out stays high while Stall=1.
  - Leaves for IDLE on the first non-stalled cycle, so Redirect is seen for exactly one unstalled cycle.
- Valid while Busy=1 (branch in the delay slot, DCTI couple) is ignored; no nesting.
- Taken_Out and Target_Out hold their last values until the next accepted branch.
- Psr_In is sampled only on acceptance; later flag changes do not affect the decision in flight.

Optional Feature:
SC_BRANCHCOND_STATS_EN
- Defined: adds output SC_BranchCond_TakenCount_Out [15:0].
  - Increments on each accepted branch evaluated as taken.
  - Saturates at 16'hFFFF.
  - Reset clears it to 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-DELAY: assert SC_Psr_RESET_InHigh asynchronously -> all outputs 0 immediately; FSM in IDLE.
- BE with Psr=0100, a=0, Pc=32'h0000_1000, Disp=22'h000004 -> Taken=1, Target=32'h0000_1010, AnnulSlot=0 in DELAY, Redirect=1 for one cycle.
- BNE with Psr=0100, a=1 -> Taken=0, AnnulSlot=1 in DELAY, no Redirect, back in IDLE after 2 cycles.
- BA with a=1, Pc=32'h0000_0000, Disp=22'h3FFFFF -> Target=32'hFFFF_FFFC (wrap); AnnulSlot=1; Redirect=1.
- BL sweep over all 16 Psr values -> Taken=N^V for each; BN never taken; BA always taken.
- Stall=1 for 3 cycles in REDIRECT -> Redirect stays high for 4 cycles; Valid pulsed during DELAY is ignored; with SC_BRANCHCOND_STATS_EN defined, TakenCount increments by exactly 1.

Source files
------------

// File: rtl/sc_branch_cond_unit.sv
// sc_branch_cond_unit: SPARC Bicc evaluation, branch target and delay-slot/redirect sequencing.
// Define SC_BRANCHCOND_STATS_EN to add a saturating taken-branch counter output.
module sc_branch_cond_unit #(
   parameter int DATAWIDTH_ALU_SELECTION = 4,
   parameter int DATAWIDTH_COND = 4,
   parameter int DATAWIDTH_DISP = 22,
   parameter int DATAWIDTH_PC = 32
) (
   input  logic                               SC_BranchCond_CLOCK_50,
   input  logic                               SC_Psr_RESET_InHigh,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_BranchCond_Psr_In,
   input  logic                               SC_BranchCond_Valid_InHigh,
   input  logic [DATAWIDTH_COND-1:0]          SC_BranchCond_Cond_In,
   input  logic                               SC_BranchCond_Annul_In,
   input  logic [DATAWIDTH_DISP-1:0]          SC_BranchCond_Disp_In,
   input  logic [DATAWIDTH_PC-1:0]            SC_BranchCond_Pc_In,
   input  logic                               SC_BranchCond_Stall_InHigh,
   output logic                               SC_BranchCond_Taken_Out,
   output logic [DATAWIDTH_PC-1:0]            SC_BranchCond_Target_Out,
   output logic                               SC_BranchCond_AnnulSlot_Out,
   output logic                               SC_BranchCond_Redirect_Out,
   output logic                               SC_BranchCond_Busy_Out
`ifdef SC_BRANCHCOND_STATS_EN
   ,output logic [15:0]                       SC_BranchCond_TakenCount_Out
`endif
);
   typedef enum logic [1:0] {IDLE, DELAY, REDIRECT} state_t;
   state_t state_q, state_d;
   logic taken_q, taken_d, annul_q, annul_d, slot_q, redirect_q, busy_q;
   logic [DATAWIDTH_PC-1:0] target_q, target_d, eval_target;
   logic n, z, v, c, base, eval_taken, eval_annul, accept;
   assign {n, z, v, c} = SC_BranchCond_Psr_In;
   // Upper half of the condition table is the complement of the lower half.
   always_comb begin
      case (SC_BranchCond_Cond_In[2:0])
         3'd0: base = 1'b0;
         3'd1: base = z;
         3'd2: base = z | (n ^ v);
         3'd3: base = n ^ v;
         3'd4: base = c | z;
         3'd5: base = c;
         3'd6: base = n;
         default: base = v;
      endcase
   end
   assign eval_taken = base ^ SC_BranchCond_Cond_In[3];
   assign eval_target = SC_BranchCond_Pc_In + {{(DATAWIDTH_PC-DATAWIDTH_DISP-2){SC_BranchCond_Disp_In[DATAWIDTH_DISP-1]}}, SC_BranchCond_Disp_In, 2'b00};
   assign eval_annul = SC_BranchCond_Annul_In & ((SC_BranchCond_Cond_In[2:0] == 3'd0) | ~eval_taken);
   assign accept = (state_q == IDLE) & SC_BranchCond_Valid_InHigh & ~SC_BranchCond_Stall_InHigh;
   assign taken_d = accept ? eval_taken : taken_q;
   assign target_d = accept ? eval_target : target_q;
   assign annul_d = accept ? eval_annul : annul_q;
   always_comb begin
      state_d = state_q;
      if (!SC_BranchCond_Stall_InHigh)
         case (state_q)
            IDLE:    state_d = SC_BranchCond_Valid_InHigh ? DELAY : IDLE;
            DELAY:   state_d = taken_q ? REDIRECT : IDLE;
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge SC_BranchCond_CLOCK_50 or posedge SC_Psr_RESET_InHigh) begin
      if (SC_Psr_RESET_InHigh) begin
         state_q    <= IDLE;
         taken_q    <= 1'b0;
         target_q   <= '0;
         annul_q    <= 1'b0;
         slot_q     <= 1'b0;
         redirect_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         taken_q    <= taken_d;
         target_q   <= target_d;
         annul_q    <= annul_d;
         slot_q     <= (state_d == DELAY) & annul_d;
         redirect_q <= state_d == REDIRECT;
         busy_q     <= state_d != IDLE;
      end
   end
   assign SC_BranchCond_Taken_Out = taken_q;
   assign SC_BranchCond_Target_Out = target_q;
   assign SC_BranchCond_AnnulSlot_Out = slot_q;
   assign SC_BranchCond_Redirect_Out = redirect_q;
   assign SC_BranchCond_Busy_Out = busy_q;
`ifdef SC_BRANCHCOND_STATS_EN
   logic [15:0] count_q;
   always_ff @(posedge SC_BranchCond_CLOCK_50 or posedge SC_Psr_RESET_InHigh) begin
      if (SC_Psr_RESET_InHigh) count_q <= '0;
      else if (accept && eval_taken && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
   end
   assign SC_BranchCond_TakenCount_Out = count_q;
`endif
endmodule

// File: tb/tb_sc_branch_cond_unit.sv
// tb_sc_branch_cond_unit: scoreboard bench with a behavioural Bicc model and randomized traffic.
module tb_sc_branch_cond_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] psr = '0, cond = '0;
   logic valid = 1'b0, annul = 1'b0, stall = 1'b0;
   logic [21:0] disp = '0;
   logic [31:0] pc = '0;
   logic taken, slot, redirect, busy;
   logic [31:0] target;
`ifdef SC_BRANCHCOND_STATS_EN
   logic [15:0] taken_cnt;
   logic [15:0] cnt_before;
`endif
   int tests = 0, fails = 0;
   int rem = 0, n_red = 0, red_hi = 0;
   logic prev_busy = 1'b0;
   logic [15:0] exp_cnt = '0;
   typedef struct {logic taken; logic [31:0] target; logic annul;} exp_t;
   exp_t sb[$];
   exp_t cur, e;

   sc_branch_cond_unit dut (
      .SC_BranchCond_CLOCK_50(clk),
      .SC_Psr_RESET_InHigh(rst),
      .SC_BranchCond_Psr_In(psr),
      .SC_BranchCond_Valid_InHigh(valid),
      .SC_BranchCond_Cond_In(cond),
      .SC_BranchCond_Annul_In(annul),
      .SC_BranchCond_Disp_In(disp),
      .SC_BranchCond_Pc_In(pc),
      .SC_BranchCond_Stall_InHigh(stall),
      .SC_BranchCond_Taken_Out(taken),
      .SC_BranchCond_Target_Out(target),
      .SC_BranchCond_AnnulSlot_Out(slot),
      .SC_BranchCond_Redirect_Out(redirect),
      .SC_BranchCond_Busy_Out(busy)
`ifdef SC_BRANCHCOND_STATS_EN
      ,.SC_BranchCond_TakenCount_Out(taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Straight transcription of the Bicc table, flags unpacked by name.
   function automatic logic ref_taken(input logic [3:0] p, input logic [3:0] cc);
      logic nf, zf, vf, cf;
      {nf, zf, vf, cf} = p;
      case (cc)
         4'd0:  return 1'b0;
         4'd1:  return zf;
         4'd2:  return zf || (nf != vf);
         4'd3:  return nf != vf;
         4'd4:  return cf || zf;
         4'd5:  return cf;
         4'd6:  return nf;
         4'd7:  return vf;
         4'd8:  return 1'b1;
         4'd9:  return !zf;
         4'd10: return !(zf || (nf != vf));
         4'd11: return nf == vf;
         4'd12: return !(cf || zf);
         4'd13: return !cf;
         4'd14: return !nf;
         default: return !vf;
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [21:0] d);
      longint t;
      t = longint'(p) + longint'($signed(d)) * 4;
      return t[31:0];
   endfunction

   // Reference: a branch occupies one unstalled delay cycle plus one unstalled redirect cycle if taken.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            rem = 0;
            exp_cnt = '0;
            sb.delete();
         end else if (rem == 0) begin
            if (valid && !stall) begin
               e.taken = ref_taken(psr, cond);
               e.target = ref_target(pc, disp);
               e.annul = annul && (cond == 4'd0 || cond == 4'd8 || !e.taken);
               sb.push_back(e);
               rem = e.taken ? 2 : 1;
               if (e.taken && exp_cnt != 16'hFFFF) exp_cnt++;
            end
         end else if (!stall) rem--;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) prev_busy = 1'b0;
         else begin
            if (busy && !prev_busy) begin
               if (sb.size() == 0) chk("spurious_busy", 32'(busy), 32'd0);
               else begin
                  cur = sb.pop_front();
                  chk("sb_taken", 32'(taken), 32'(cur.taken));
                  chk("sb_target", target, cur.target);
`ifdef SC_BRANCHCOND_STATS_EN
                  chk("sb_count", 32'(taken_cnt), 32'(exp_cnt));
`endif
                  n_red = 0;
               end
            end
            if (busy) begin
               if (redirect) begin
                  chk("slot_in_redirect", 32'(slot), 32'd0);
                  if (!stall) n_red++;
               end else chk("slot_in_delay", 32'(slot), 32'(cur.annul));
            end else chk("redirect_idle", 32'({redirect, slot}), 32'd0);
            if (!busy && prev_busy) chk("redirect_cycles", 32'(n_red), 32'(cur.taken));
            prev_busy = busy;
         end
      end
   end

   task automatic issue(input logic [3:0] p, input logic [3:0] cc, input logic a, input logic [21:0] d, input logic [31:0] pcv);
      psr = p; cond = cc; annul = a; disp = d; pc = pcv; valid = 1'b1; stall = 1'b0;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy && i < 40) begin
         @(posedge clk); #1;
         i++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", {taken, slot, redirect, busy}, 32'd0);
      chk("rst_target", target, 32'd0);
      rst = 1'b0;
      issue(4'b0100, 4'b0001, 1'b0, 22'h000004, 32'h0000_1000);
      chk("be_taken", 32'(taken), 32'd1);
      chk("be_target", target, 32'h0000_1010);
      chk("be_slot", 32'(slot), 32'd0);
      @(posedge clk); #1;
      chk("be_redirect", 32'(redirect), 32'd1);
      wait_idle();
      issue(4'b0100, 4'b1001, 1'b1, 22'h000010, 32'h0000_2000);
      chk("bne_taken", 32'(taken), 32'd0);
      chk("bne_slot", 32'(slot), 32'd1);
      @(posedge clk); #1;
      chk("bne_idle", 32'({busy, redirect}), 32'd0);
      issue(4'b0000, 4'b1000, 1'b1, 22'h3FFFFF, 32'h0000_0000);
      chk("ba_wrap_target", target, 32'hFFFF_FFFC);
      chk("ba_slot", 32'(slot), 32'd1);
      wait_idle();
      for (int p = 0; p < 16; p++) begin
         logic [3:0] pv;
         pv = 4'(p);
         issue(pv, 4'b0011, 1'b0, 22'(p), 32'h100);
         chk("bl_taken", 32'(taken), 32'(pv[3] ^ pv[1]));
         wait_idle();
         issue(pv, 4'b0000, 1'b0, 22'h1, 32'h200);
         chk("bn_taken", 32'(taken), 32'd0);
         wait_idle();
         issue(pv, 4'b1000, 1'b0, 22'h1, 32'h300);
         chk("ba_taken", 32'(taken), 32'd1);
         wait_idle();
      end
`ifdef SC_BRANCHCOND_STATS_EN
      cnt_before = taken_cnt;
`endif
      issue(4'b0000, 4'b1000, 1'b0, 22'h000008, 32'h0000_0100);
      psr = 4'hF; cond = 4'b0000; disp = 22'h123; pc = 32'h5000; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      red_hi = 0;
      for (int i = 0; i < 6; i++) begin
         if (redirect) red_hi++;
         stall = (i < 3);
         @(posedge clk); #1;
      end
      chk("stall_redirect_len", 32'(red_hi), 32'd4);
      chk("dcti_target_kept", target, 32'h0000_0120);
      chk("dcti_taken_kept", 32'(taken), 32'd1);
`ifdef SC_BRANCHCOND_STATS_EN
      chk("count_plus_one", 32'(taken_cnt - cnt_before), 32'd1);
`endif
      wait_idle();
      issue(4'b0100, 4'b0001, 1'b1, 22'h000004, 32'h0000_1000);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_outputs", {taken, slot, redirect, busy}, 32'd0);
      chk("async_rst_target", target, 32'd0);
      #4 rst = 1'b0;
      repeat (3000) begin
         @(posedge clk); #1;
         valid = 1'($urandom_range(0, 1));
         stall = ($urandom_range(0, 3) == 0);
         psr = 4'($urandom);
         cond = 4'($urandom);
         annul = 1'($urandom);
         disp = 22'($urandom);
         pc = $urandom;
      end
      valid = 1'b0;
      stall = 1'b0;
      @(posedge clk); #1;
      wait_idle();
      @(posedge clk); #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("model_idle", 32'(rem), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
